systolic_sequencer: RTL and testbench
=====================================

Name: systolic_sequencer

Overview:
- Run-level controller for the MATRIX_SIZE x MATRIX_SIZE weight-stationary systolic array.
- One start request runs three phases in order: row-by-row weight load, skewed activation feed, then a fixed pipeline drain.
- It drives the array's per-row load_weight and enable_mult controls and the operand-buffer addresses.
- It reports progress through a busy/done handshake. It supports stall (general_enable) and abort.

Parameters:
MATRIX_SIZE, 2, array dimension N; legal range 2..16.
DRAIN_CYCLES, 4*MATRIX_SIZE, cycles to flush PE pipelines after last activation; must be >= 1.
CW, $clog2(2*MATRIX_SIZE), width of address/count outputs (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
general_enable  input  1  global advance; low = stall
start  input  1  run request, sampled in IDLE only
abort  input  1  synchronous cancel of a run in progress
load_weight  output  MATRIX_SIZE  one-hot row weight-load strobe
enable_mult  output  MATRIX_SIZE  per-row MAC enable
weight_row_addr  output  CW  weight buffer row index during LOAD
act_valid  output  MATRIX_SIZE  per-row skewed activation valid
feed_count  output  CW  activation column step during FEED
busy  output  1  run in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: async assertion forces IDLE. While reset_n is low, every output is 0: load_weight, enable_mult, act_valid, weight_row_addr, feed_count, busy and done. Release is synchronous to clk.
- States: IDLE, LOAD, FEED, DRAIN, DONE (5-state FSM, binary or one-hot at implementer's choice).
- All outputs are registered. A value shown "in cycle k" is visible after the k-th rising edge following the accepting edge.
- IDLE:
  - Start is accepted when start=1 and general_enable=1 → LOAD.
  - start is ignored in every other state; no queuing.
- LOAD: lasts N cycles, numbered k = 0..N-1.
  - load_weight has only bit k set.
  - weight_row_addr = k.
  - enable_mult = 0.
  - After k = N-1 → FEED.
- FEED: lasts 2N-1 cycles, numbered f = 0..2N-2.
  - feed_count = f.
  - act_valid[r] = 1 iff r <= f <= r+N-1.
  - enable_mult = all ones.
  - load_weight = 0.
  - After f = 2N-2 → DRAIN.
- DRAIN: lasts DRAIN_CYCLES cycles.
  - enable_mult = all ones.
  - act_valid = 0.
  - feed_count holds 0.
  - After the last drain cycle → DONE.
- DONE: lasts exactly 1 cycle.
  - done = 1, busy = 0, enable_mult = 0.
  - Then → IDLE.
- busy = 1 in LOAD, FEED and DRAIN; 0 in IDLE and DONE.
- Total run: cycles 1..N in LOAD, N+1..3N-1 in FEED, 3N..3N+DRAIN_CYCLES-1 in DRAIN, done in cycle 3N+DRAIN_CYCLES.
- Stall (general_enable = 0):
  - State and all counters freeze.
  - load_weight, enable_mult and act_valid are forced to 0 for that cycle.
  - busy, weight_row_addr and feed_count hold their values.
  - A DONE state reached while stalled holds done = 0 until general_enable returns. The pulse is then exactly one enabled cycle.
- Abort:
  - abort = 1 in LOAD, FEED or DRAIN → IDLE on the next edge. Abort takes effect regardless of general_enable.
  - All outputs go to 0 and done is never pulsed for an aborted run.
  - abort in IDLE or DONE has no effect (DONE still pulses).
  - If start and abort are both high in IDLE, start wins.
- Counters saturate at their terminal value. No wrap-around is permitted.
- The phase transition happens on the terminal count in the same edge; there are no idle bubbles between phases.
- Mid-run reset: immediate return to IDLE and all outputs 0; no done.

Test Plan:
- N=2, DRAIN=8, start pulse in IDLE →
  - load_weight 01 (addr 0) in cycle 1 and 10 (addr 1) in cycle 2.
  - act_valid 01, 11, 10 in cycles 3–5, with feed_count 0, 1, 2.
  - enable_mult 11 in cycles 3–13.
  - done = 1 in cycle 14 only; busy high in cycles 1–13.
- N=2, start held high continuously → a new run begins only on the IDLE cycle after DONE. The second done arrives 15 cycles after the first.
- N=4, general_enable low for 3 cycles during FEED at f=2 →
  - act_valid and enable_mult are 0 while stalled and feed_count holds 2.
  - The run resumes at f=3; done arrives 3 cycles late (cycle 12+DRAIN_CYCLES+3).
- N=2, abort in DRAIN cycle 7 → busy 0 and enable_mult 00 next cycle; done never asserts. A fresh start then gives a full normal run.
- Deassert reset_n asynchronously in mid-FEED (between edges) → all outputs 0 immediately. After release with start=0, the block stays IDLE.
- start while busy (LOAD/FEED/DRAIN) and abort in IDLE → no state change and no extra done; the current run completes with exact nominal timing.

Source files
------------

// File: rtl/systolic_sequencer_if.sv
// Control bundle between the systolic run sequencer and its requester / array.
// master = the sequencer, slave = the side that issues run requests.
interface systolic_sequencer_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int CW          = $clog2(2*MATRIX_SIZE)
);
    logic                   general_enable;
    logic                   start;
    logic                   abort;
    logic [MATRIX_SIZE-1:0] load_weight;
    logic [MATRIX_SIZE-1:0] enable_mult;
    logic [CW-1:0]          weight_row_addr;
    logic [MATRIX_SIZE-1:0] act_valid;
    logic [CW-1:0]          feed_count;
    logic                   busy;
    logic                   done;

    modport master (
        input  general_enable, start, abort,
        output load_weight, enable_mult, weight_row_addr, act_valid,
               feed_count, busy, done
    );

    modport slave (
        output general_enable, start, abort,
        input  load_weight, enable_mult, weight_row_addr, act_valid,
               feed_count, busy, done
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Run-level controller for a weight-stationary systolic array: weight load,
// skewed activation feed and pipeline drain, with stall and abort.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_LOAD  | one weight row per cycle, r_cnt = row
// S_FEED  | skewed activation columns, r_cnt = column step
// S_DRAIN | flushing PE pipelines, r_drain counts down to 0
// S_DONE  | one-cycle completion report
module systolic_sequencer #(
    parameter int MATRIX_SIZE  = 2,
    parameter int DRAIN_CYCLES = 4*MATRIX_SIZE
) (
    input logic                  clk,
    input logic                  reset_n,
    systolic_sequencer_if.master bus
);
    localparam int CW = $clog2(2*MATRIX_SIZE);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic [CW-1:0]          LOAD_LAST  = CW'(MATRIX_SIZE-1);
    localparam logic [CW-1:0]          FEED_LAST  = CW'(2*MATRIX_SIZE-2);
    localparam logic [DW-1:0]          DRAIN_INIT = DW'(DRAIN_CYCLES-1);
    localparam logic [MATRIX_SIZE-1:0] ROW0       = MATRIX_SIZE'(1);
    localparam logic [MATRIX_SIZE-1:0] ONES       = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [DW-1:0]          r_drain;
    logic [MATRIX_SIZE-1:0] r_lw;
    logic [MATRIX_SIZE-1:0] r_em;
    logic [MATRIX_SIZE-1:0] r_av;
    logic [CW-1:0]          r_addr;
    logic [CW-1:0]          r_fc;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_in_run;

    // Row r sees activation column f while r <= f <= r+N-1.
    function automatic logic [MATRIX_SIZE-1:0] av_of(input logic [CW-1:0] f);
        logic [MATRIX_SIZE-1:0] v;
        v = '0;
        for (int r = 0; r < MATRIX_SIZE; r++)
            v[r] = (int'(f) >= r) && (int'(f) <= r + MATRIX_SIZE - 1);
        return v;
    endfunction

    assign w_in_run = (r_state == S_LOAD) || (r_state == S_FEED) || (r_state == S_DRAIN);

    // Outputs are decoded from the state held before each edge, so they trail the FSM by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
            r_lw    <= '0;
            r_em    <= '0;
            r_av    <= '0;
            r_addr  <= '0;
            r_fc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.abort && w_in_run) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
            r_lw    <= '0;
            r_em    <= '0;
            r_av    <= '0;
            r_addr  <= '0;
            r_fc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!bus.general_enable) begin
            r_lw   <= '0;
            r_em   <= '0;
            r_av   <= '0;
            r_done <= 1'b0;
        end else begin
            r_lw   <= (r_state == S_LOAD) ? (ROW0 << r_cnt) : '0;
            r_addr <= (r_state == S_LOAD) ? r_cnt : '0;
            r_em   <= ((r_state == S_FEED) || (r_state == S_DRAIN)) ? ONES : '0;
            r_av   <= (r_state == S_FEED) ? av_of(r_cnt) : '0;
            r_fc   <= (r_state == S_FEED) ? r_cnt : '0;
            r_busy <= w_in_run;
            r_done <= (r_state == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == LOAD_LAST) begin
                        r_state <= S_FEED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FEED: begin
                    if (r_cnt == FEED_LAST) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= '0;
                        r_drain <= DRAIN_INIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0)
                        r_state <= S_DONE;
                    else
                        r_drain <= r_drain - DW'(1);
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_weight     = r_lw;
    assign bus.enable_mult     = r_em;
    assign bus.act_valid       = r_av;
    assign bus.weight_row_addr = r_addr;
    assign bus.feed_count      = r_fc;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: N=2/DRAIN=8 and N=4/DRAIN=16 instances
// covering nominal runs, held start, stall, abort and mid-run reset.
module tb_systolic_sequencer;
    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    systolic_sequencer_if #(.MATRIX_SIZE(2)) if2 ();
    systolic_sequencer_if #(.MATRIX_SIZE(4)) if4 ();

    systolic_sequencer #(.MATRIX_SIZE(2), .DRAIN_CYCLES(8)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(if2.master));
    systolic_sequencer #(.MATRIX_SIZE(4)) u4 (
        .clk(clk), .reset_n(reset_n), .bus(if4.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input int lw, input int em, input int av,
                        input int busy, input int done, input int addr, input int fc);
        chk({tag, ".lw"},   32'(if2.load_weight), lw);
        chk({tag, ".em"},   32'(if2.enable_mult), em);
        chk({tag, ".av"},   32'(if2.act_valid),   av);
        chk({tag, ".busy"}, 32'(if2.busy),        busy);
        chk({tag, ".done"}, 32'(if2.done),        done);
        if (addr >= 0) chk({tag, ".addr"}, 32'(if2.weight_row_addr), addr);
        if (fc >= 0)   chk({tag, ".fc"},   32'(if2.feed_count),      fc);
    endtask

    // Full N=2, DRAIN=8 run from an IDLE start pulse, checked cycle by cycle.
    // poke: hold abort on the accepting edge and start high through the run.
    task automatic check_run2(input string tag, input bit poke);
        int lw, em, av, addr, fc;
        if2.start = 1'b1;
        if2.abort = poke;
        tick();
        if2.start = 1'b0;
        if2.abort = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            lw = 0; av = 0; addr = -1; fc = -1;
            em = (c >= 3 && c <= 13) ? 3 : 0;
            case (c)
                1: begin lw = 1; addr = 0; end
                2: begin lw = 2; addr = 1; end
                3: begin av = 1; fc = 0; end
                4: begin av = 3; fc = 1; end
                5: begin av = 2; fc = 2; end
                default: if (c >= 6 && c <= 13) fc = 0;
            endcase
            chk2($sformatf("%s.c%0d", tag, c), lw, em, av, (c <= 13) ? 1 : 0,
                 (c == 14) ? 1 : 0, addr, fc);
            if2.start = poke && (c <= 12);
        end
        if2.start = 1'b0;
    endtask

    initial begin
        int  t1, t2, t_done, n_done;
        bit  seen;
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        if2.general_enable = 1'b1; if2.start = 1'b0; if2.abort = 1'b0;
        if4.general_enable = 1'b1; if4.start = 1'b0; if4.abort = 1'b0;

        // Reset state
        #12;
        chk2("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.u4.busy", 32'(if4.busy), 0);
        chk("reset.u4.em",   32'(if4.enable_mult), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk2("idle", 0, 0, 0, 0, 0, 0, 0);

        // Nominal run
        check_run2("run1", 1'b0);

        // Start held high: second done 15 cycles after the first
        t1 = -1; t2 = -1;
        if2.start = 1'b1;
        for (int t = 1; t <= 40 && t2 < 0; t++) begin
            tick();
            if (if2.done === 1'b1) begin
                if (t1 < 0) t1 = t;
                else begin
                    t2 = t;
                    if2.start = 1'b0;
                end
            end
        end
        if2.start = 1'b0;
        chk("held.first_done", t1, 15);
        chk("held.gap", t2 - t1, 15);
        tick(); tick();
        chk("held.idle_busy", 32'(if2.busy), 0);

        // Abort in DRAIN cycle 7, then a fresh full run
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        chk2("abort.pre", 0, 3, 0, 1, 0, -1, 0);
        if2.abort = 1'b1;
        tick();
        if2.abort = 1'b0;
        chk2("abort.post", 0, 0, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (if2.done !== 1'b0 || if2.busy !== 1'b0) seen = 1'b1;
        end
        chk("abort.no_done", 32'(seen), 0);
        check_run2("run2", 1'b0);

        // Abort in IDLE ignored; start beats abort; start while busy ignored
        if2.abort = 1'b1;
        tick(); tick();
        chk("idle_abort.busy", 32'(if2.busy), 0);
        chk("idle_abort.done", 32'(if2.done), 0);
        check_run2("run3", 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (if2.done !== 1'b0 || if2.busy !== 1'b0) seen = 1'b1;
        end
        chk("run3.no_rerun", 32'(seen), 0);

        // N=4 stall during FEED at f=2
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        tick();
        chk("n4.c1.lw", 32'(if4.load_weight), 32'h1);
        chk("n4.c1.addr", 32'(if4.weight_row_addr), 0);
        tick(); tick(); tick();
        chk("n4.c4.lw", 32'(if4.load_weight), 32'h8);
        chk("n4.c4.addr", 32'(if4.weight_row_addr), 3);
        tick();
        chk("n4.c5.av", 32'(if4.act_valid), 32'h1);
        chk("n4.c5.em", 32'(if4.enable_mult), 32'hf);
        chk("n4.c5.lw", 32'(if4.load_weight), 0);
        tick(); tick();
        chk("n4.c7.fc", 32'(if4.feed_count), 2);
        chk("n4.c7.av", 32'(if4.act_valid), 32'h7);
        if4.general_enable = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("n4.stall%0d.av", s), 32'(if4.act_valid), 0);
            chk($sformatf("n4.stall%0d.em", s), 32'(if4.enable_mult), 0);
            chk($sformatf("n4.stall%0d.fc", s), 32'(if4.feed_count), 2);
            chk($sformatf("n4.stall%0d.busy", s), 32'(if4.busy), 1);
        end
        if4.general_enable = 1'b1;
        tick();
        chk("n4.resume.fc", 32'(if4.feed_count), 3);
        chk("n4.resume.av", 32'(if4.act_valid), 32'hf);
        chk("n4.resume.em", 32'(if4.enable_mult), 32'hf);
        tick();
        chk("n4.f4.av", 32'(if4.act_valid), 32'he);
        t_done = -1; n_done = 0;
        for (int t = 13; t <= 50; t++) begin
            tick();
            if (if4.done === 1'b1) begin
                n_done++;
                if (t_done < 0) t_done = t;
            end
        end
        chk("n4.done_cycle", t_done, 31);
        chk("n4.done_width", n_done, 1);

        // Asynchronous reset in mid-FEED
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        chk("mreset.pre.fc", 32'(if2.feed_count), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk2("mreset.async", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (if2.busy !== 1'b0 || if2.done !== 1'b0 || if2.load_weight !== 2'b00) seen = 1'b1;
        end
        chk("mreset.stays_idle", 32'(seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
